// File: rtl/tc_host.sv
// tc_host: command-to-peripheral bus bridge with a timer-interrupt dispatcher.
// Host commands are turned into single-cycle peripheral write/read strobes.
// A pending, globally enabled interrupt takes priority over commands: the
// dispatcher reads TIMSK and TIFR and picks the highest-priority pending
// source. It then clears that flag, pulses the vector and waits for the
// request line to drop.
module tc_host #(
  parameter logic [7:0]  TIFR_ADDR  = 8'h15,
  parameter logic [7:0]  TIMSK_ADDR = 8'h6E,
  parameter int unsigned HOLD_MAX   = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_we,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       write,
  output logic       read,
  output logic [7:0] addr,
  output logic [7:0] wdata,
  input  logic [7:0] rdata,
  input  logic       interrupt_request,
  input  logic       status_reg_interrupt_enable,
  output logic       interrupt_executed,
  output logic [1:0] irq_vec,
  output logic       irq_vec_valid
);

  // Hold counter reads 1 in the first IHOLD cycle, so leaving at HOLD_MAX-1
  // puts IDLE exactly HOLD_MAX cycles after IACK.
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

  typedef enum logic [3:0] {
    IDLE, CW, CR, CRW, RSP, IM, IMW, IF, IFW, ICLR, IACK, IHOLD
  } state_t;

  state_t      state, next;
  logic        take_irq;
  logic [2:0]  timsk;
  logic [2:0]  pending;
  logic [1:0]  vec_sel;
  logic [1:0]  vec_q;
  logic [3:0]  hold_cnt;

  assign take_irq  = interrupt_request && status_reg_interrupt_enable;
  assign cmd_ready = rst && (state == IDLE) && !take_irq;

  // Pending sources from TIFR (on rdata during IFW) masked by TIMSK; OCA > OCB > OVF.
  always_comb begin
    pending = rdata[2:0] & timsk;
    vec_sel = 2'd0;
    if (pending[1])      vec_sel = 2'd1;
    else if (pending[2]) vec_sel = 2'd2;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next;
  end

  // Next-state logic; an interrupt sequence never looks at the enable again.
  always_comb begin
    next = state;
    case (state)
      IDLE: begin
        if (take_irq)       next = IM;
        else if (cmd_valid) next = cmd_we ? CW : CR;
      end
      CW:    next = RSP;
      CR:    next = CRW;
      CRW:   next = RSP;
      RSP:   next = IDLE;
      IM:    next = IMW;
      IMW:   next = IF;
      IF:    next = IFW;
      IFW:   next = (pending != 3'b000) ? ICLR : IDLE;
      ICLR:  next = IACK;
      IACK:  next = IHOLD;
      IHOLD: if (!interrupt_request || hold_cnt >= HOLD_LAST) next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with
  // the state they belong to; addr/wdata only move when a strobe is issued.
  always_ff @(posedge clk) begin
    if (!rst) begin
      write              <= 1'b0;
      read               <= 1'b0;
      rsp_valid          <= 1'b0;
      interrupt_executed <= 1'b0;
      irq_vec_valid      <= 1'b0;
      addr               <= '0;
      wdata              <= '0;
      rsp_rdata          <= '0;
      irq_vec            <= '0;
      vec_q              <= '0;
      timsk              <= '0;
      hold_cnt           <= '0;
    end else begin
      write              <= (next == CW) || (next == ICLR);
      read               <= (next == CR) || (next == IM) || (next == IF);
      rsp_valid          <= (next == RSP);
      interrupt_executed <= (next == IACK);
      irq_vec_valid      <= (next == IACK);
      case (next)
        CW: begin
          addr  <= cmd_addr;
          wdata <= cmd_wdata;
        end
        CR:   addr <= cmd_addr;
        IM:   addr <= TIMSK_ADDR;
        IF:   addr <= TIFR_ADDR;
        ICLR: begin
          addr  <= TIFR_ADDR;
          wdata <= 8'd1 << vec_sel;
        end
        IACK: irq_vec <= vec_q;
        default: ;
      endcase
      if (state == IMW) timsk <= rdata[2:0];
      if (state == IFW) vec_q <= vec_sel;
      if (state == CRW)     rsp_rdata <= rdata;
      else if (state == CW) rsp_rdata <= '0;
      if (state == IACK)                         hold_cnt <= 4'd1;
      else if (state == IHOLD && hold_cnt != '1) hold_cnt <= hold_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_tc_host.sv
// Bench for tc_host: a peripheral model with a memory and fixed TIMSK/TIFR
// values, a bus monitor logging events by cycle, and a transaction-level
// reference that predicts event cycles and data from the protocol rules.
module tb_tc_host;

  localparam int HOLD_MAX = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_we;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       write, read;
  logic [7:0] addr, wdata, rdata;
  logic       interrupt_request, status_reg_interrupt_enable;
  logic       interrupt_executed, irq_vec_valid;
  logic [1:0] irq_vec;

  tc_host #(.TIFR_ADDR(8'h15), .TIMSK_ADDR(8'h6E), .HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .write(write), .read(read), .addr(addr), .wdata(wdata), .rdata(rdata),
    .interrupt_request(interrupt_request),
    .status_reg_interrupt_enable(status_reg_interrupt_enable),
    .interrupt_executed(interrupt_executed), .irq_vec(irq_vec),
    .irq_vec_valid(irq_vec_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Peripheral: registered read data; TIMSK/TIFR are bench-controlled values.
  logic [7:0] per_mem [256];
  logic [7:0] timsk_v = 8'h00, tifr_v = 8'h00;
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) per_mem[i] <= 8'(i * 7 + 3);
    end else begin
      if (read) rdata <= (addr == 8'h15) ? tifr_v : (addr == 8'h6E) ? timsk_v : per_mem[addr];
      if (write && addr != 8'h15 && addr != 8'h6E) per_mem[addr] <= wdata;
    end
  end

  typedef struct { int cyc; logic [7:0] a; logic [7:0] d; } ev_t;
  ev_t wq[$], rq[$], sq[$], iq[$];
  int  excl_err = 0;

  always @(negedge clk) begin
    if (write && read) excl_err++;
    if (write) wq.push_back('{cyc, addr, wdata});
    if (read) rq.push_back('{cyc, addr, 8'h00});
    if (rsp_valid) sq.push_back('{cyc, 8'h00, rsp_rdata});
    if (interrupt_executed || irq_vec_valid)
      iq.push_back('{cyc, {6'b0, irq_vec}, {6'b0, interrupt_executed, irq_vec_valid}});
  end

  int n_checks = 0, n_errors = 0;
  logic [7:0] ref_mem [256];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_ref();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
  endtask

  task automatic clear_q();
    wq.delete(); rq.delete(); sq.delete(); iq.delete();
  endtask

  function automatic logic [7:0] safe_addr(input logic [7:0] a);
    return (a == 8'h15 || a == 8'h6E) ? (a ^ 8'h80) : a;
  endfunction

  // Checks the bus and response events belonging to a command accepted at acc.
  task automatic check_cmd(input bit we, input logic [7:0] a, input logic [7:0] d, input int acc);
    int nw = 0, nr = 0, ns = 0, lat;
    ev_t w = '{0, 0, 0}, r = '{0, 0, 0}, s = '{0, 0, 0};
    logic [7:0] exp_r;
    foreach (wq[i]) if (wq[i].cyc > acc) begin nw++; w = wq[i]; end
    foreach (rq[i]) if (rq[i].cyc > acc) begin nr++; r = rq[i]; end
    foreach (sq[i]) if (sq[i].cyc > acc) begin ns++; s = sq[i]; end
    if (we) begin
      check("wr_count", nw, 1);
      check("wr_cycle", w.cyc, acc + 1);
      check("wr_addr", w.a, a);
      check("wr_data", w.d, d);
      check("wr_no_read", nr, 0);
      ref_mem[a] = d;
      exp_r = 8'h00;
      lat = 2;
    end else begin
      check("rd_count", nr, 1);
      check("rd_cycle", r.cyc, acc + 1);
      check("rd_addr", r.a, a);
      check("rd_no_write", nw, 0);
      exp_r = ref_mem[a];
      lat = 3;
    end
    check("rsp_count", ns, 1);
    check("rsp_cycle", s.cyc, acc + lat);
    check("rsp_data", s.d, exp_r);
  endtask

  task automatic cmd_test(input bit we, input logic [7:0] a, input logic [7:0] d);
    int acc = -1;
    clear_q();
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
    for (int k = 0; k < 50 && acc < 0; k++) begin
      if (cmd_ready) acc = cyc;
      tick();
    end
    cmd_valid = 1'b0;
    if (acc < 0) check("cmd_accept_timeout", 0, 1);
    else begin
      repeat (5) tick();
      check_cmd(we, a, d, acc);
    end
  endtask

  // Interrupt with a competing write command; request drops doff cycles after
  // the take, enable optionally drops mid-sequence.
  task automatic run_irq(input logic [7:0] tm, input logic [7:0] tf, input int doff, input bit en_drop);
    int s, acc = -1, idle_exp, nr = 0, nw = 0;
    logic [2:0] p;
    logic [1:0] vec;
    logic [7:0] ca, cd;
    p = tf[2:0] & tm[2:0];
    vec = p[1] ? 2'd1 : p[2] ? 2'd2 : 2'd0;
    ca = safe_addr(8'($urandom)); cd = 8'($urandom);
    timsk_v = tm; tifr_v = tf;
    clear_q();
    s = cyc;
    interrupt_request = 1'b1; status_reg_interrupt_enable = 1'b1;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = ca; cmd_wdata = cd;
    #1 check("irq_blocks_ready", cmd_ready, 0);
    if (p == 3'b000) idle_exp = s + 5;
    else begin
      idle_exp = ((s + doff > s + 7) ? s + doff : s + 7) + 1;
      if (idle_exp > s + 6 + HOLD_MAX) idle_exp = s + 6 + HOLD_MAX;
    end
    for (int k = 0; k < 60 && acc < 0; k++) begin
      if (k > 0) tick();
      if (cyc - s == doff) interrupt_request = 1'b0;
      if (en_drop && cyc - s == 2) status_reg_interrupt_enable = 1'b0;
      #1;
      if (cmd_ready) acc = cyc;
    end
    if (acc >= 0) tick();
    cmd_valid = 1'b0;
    interrupt_request = 1'b0;
    repeat (6) tick();
    status_reg_interrupt_enable = 1'b1;
    if (acc < 0) begin
      check("irq_accept_timeout", 0, 1);
      return;
    end
    check("irq_idle_cycle", acc, idle_exp);
    foreach (rq[i]) if (rq[i].cyc < acc) nr++;
    foreach (wq[i]) if (wq[i].cyc < acc) nw++;
    check("irq_read_count", nr, 2);
    check("timsk_rd_cycle", rq[0].cyc, s + 1);
    check("timsk_rd_addr", rq[0].a, 8'h6E);
    check("tifr_rd_cycle", rq[1].cyc, s + 3);
    check("tifr_rd_addr", rq[1].a, 8'h15);
    if (p != 3'b000) begin
      check("clr_count", nw, 1);
      check("clr_cycle", wq[0].cyc, s + 5);
      check("clr_addr", wq[0].a, 8'h15);
      check("clr_data", wq[0].d, 8'd1 << vec);
      check("exe_count", iq.size(), 1);
      check("exe_cycle", iq[0].cyc, s + 6);
      check("exe_vec", iq[0].a, vec);
      check("exe_flags", iq[0].d, 3);
    end else begin
      check("spur_no_write", nw, 0);
      check("spur_no_exe", iq.size(), 0);
    end
    check_cmd(1'b1, ca, cd, acc);
  endtask

  initial begin
    int s;
    logic [7:0] tm, tf;
    rst = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    interrupt_request = 1'b0; status_reg_interrupt_enable = 1'b0;
    init_ref();
    repeat (3) tick();
    check("rst_write", write, 0);
    check("rst_read", read, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_int_exec", interrupt_executed, 0);
    check("rst_vec_valid", irq_vec_valid, 0);
    check("rst_addr", addr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_irq_vec", irq_vec, 0);
    cmd_valid = 1'b1;
    #1 check("rst_cmd_ready", cmd_ready, 0);
    cmd_valid = 1'b0;
    rst = 1'b1;
    tick();

    cmd_test(1'b1, 8'h27, 8'h40);
    cmd_test(1'b1, 8'h26, 8'h5A);
    cmd_test(1'b0, 8'h26, 8'h00);
    check("read_5a", sq[0].d, 8'h5A);

    run_irq(8'h07, 8'h07, 2, 1'b0);
    run_irq(8'h01, 8'h04, 2, 1'b0);

    // Request stuck high: IDLE HOLD_MAX cycles after IACK, then a new sequence.
    timsk_v = 8'h07; tifr_v = 8'h04;
    clear_q();
    s = cyc;
    interrupt_request = 1'b1; status_reg_interrupt_enable = 1'b1;
    repeat (24) tick();
    interrupt_request = 1'b0;
    check("hold_exe_cycle", iq[0].cyc, s + 6);
    check("hold_exe_vec", iq[0].a, 2);
    begin
      int restart = -1;
      foreach (rq[i]) if (rq[i].a == 8'h6E && rq[i].cyc > s + 1 && restart < 0) restart = rq[i].cyc;
      check("hold_restart", restart, s + 6 + HOLD_MAX + 1);
    end
    repeat (25) tick();

    // Reset in IFW aborts the sequence.
    timsk_v = 8'h07; tifr_v = 8'h02;
    clear_q();
    s = cyc;
    interrupt_request = 1'b1; status_reg_interrupt_enable = 1'b1;
    repeat (4) tick();
    rst = 1'b0;
    #1 check("rst_hold_ready", cmd_ready, 0);
    tick();
    rst = 1'b1; interrupt_request = 1'b0;
    #1;
    check("rst_abort_cycle", cyc, s + 5);
    check("rst_abort_write", write, 0);
    check("rst_abort_read", read, 0);
    check("rst_abort_addr", addr, 0);
    check("rst_abort_idle", cmd_ready, 1);
    init_ref();
    repeat (6) tick();
    check("rst_no_exe", iq.size(), 0);
    check("rst_no_write", wq.size(), 0);

    for (int it = 0; it < 30; it++) begin
      int r;
      r = int'($urandom % 3);
      if (r < 2) cmd_test(r == 0, safe_addr(8'($urandom)), 8'($urandom));
      else begin
        tm = 8'($urandom); tf = 8'($urandom);
        if ((tm[2:0] & tf[2:0]) == 3'b000) run_irq(tm, tf, 1 + int'($urandom % 4), 1'($urandom));
        else run_irq(tm, tf, 1 + int'($urandom % 20), 1'($urandom));
      end
      repeat ($urandom % 3) tick();
    end

    check("strobe_exclusive", excl_err, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
